// File: rtl/stat_pkg.sv
// stat_pkg: opcode and FSM state encodings shared by the stat sequencer files
package stat_pkg;
  typedef enum logic [1:0] {
    OP_MAX = 2'b00,
    OP_MIN = 2'b01,
    OP_AVG = 2'b10,
    OP_RSV = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_ACC,
    ST_DIV,
    ST_DONE
  } state_e;
endpackage

// File: rtl/stat_count_reg.sv
// stat_count_reg: 8-bit element counter with load/decrement and next-is-zero flag
module stat_count_reg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] load_val_i,
  output logic       cnt_zero
);
  logic [7:0] cnt_q, cnt_d;
  // load wins over decrement; the flag looks at the value about to be stored
  always_comb begin
    cnt_d    = load_i ? load_val_i : dec_i ? cnt_q - 1'b1 : cnt_q;
    cnt_zero = cnt_d == 8'd0;
  end
  // counter state
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/stat_sequencer.sv
// stat_sequencer: reads N elements from memory and reports their MAX, MIN or truncated AVG
module stat_sequencer
  import stat_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [1:0]    opcode,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    length,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result
);
  localparam int SW = DW + 8;
  localparam int CW = $clog2(SW + 1);
  state_e        state_q, state_d;
  op_e           op_q;
  logic [AW-1:0] base_q, ptr_q;
  logic [7:0]    len_q, rem_q, rem_n;
  logic [DW-1:0] acc_q, acc_n, result_q;
  logic [SW-1:0] sum_q, sum_n;
  logic [CW-1:0] div_q;
  logic [8:0]    rem_t;
  logic          err_q, cnt_zero, bad, q_bit, div_last;
  stat_count_reg u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (state_q == ST_LOAD),
    .dec_i      (state_q == ST_ACC),
    .load_val_i (len_q),
    .cnt_zero   (cnt_zero)
  );
  // comparator and one restoring-division step (remainder always < N, so 8 bits hold it)
  always_comb begin
    bad      = len_q == 8'd0 || op_q == OP_RSV;
    acc_n    = op_q == OP_MAX ? (mem_data > acc_q ? mem_data : acc_q)
                              : (mem_data < acc_q ? mem_data : acc_q);
    rem_t    = {rem_q, sum_q[SW-1]};
    q_bit    = rem_t >= {1'b0, len_q};
    rem_n    = q_bit ? 8'(rem_t - {1'b0, len_q}) : rem_t[7:0];
    sum_n    = {sum_q[SW-2:0], q_bit};
    div_last = div_q == CW'(SW - 1);
  end
  // state register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = bad ? ST_DONE : ST_FETCH;
      ST_FETCH: state_d = ST_ACC;
      ST_ACC:   state_d = !cnt_zero ? ST_FETCH : op_q == OP_AVG ? ST_DIV : ST_DONE;
      ST_DIV:   if (div_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // outputs decoded from the current state
  always_comb begin
    busy     = state_q != ST_IDLE;
    done     = state_q == ST_DONE;
    mem_rd   = state_q == ST_FETCH;
    mem_addr = ptr_q;
    err      = err_q;
    result   = result_q;
  end
  // datapath; result and err are written on the edge entering DONE so they are valid with done
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      op_q     <= OP_MAX;
      base_q   <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          op_q   <= op_e'(opcode);
          base_q <= base_addr;
          len_q  <= length;
          err_q  <= 1'b0;
        end
        ST_LOAD: begin
          ptr_q <= base_q;
          sum_q <= '0;
          rem_q <= '0;
          div_q <= '0;
          acc_q <= {DW{op_q == OP_MIN}};
          if (bad) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end
        end
        ST_ACC: begin
          ptr_q <= ptr_q + 1'b1;
          if (op_q == OP_AVG) sum_q <= sum_q + SW'(mem_data);
          else                acc_q <= acc_n;
          if (cnt_zero && op_q != OP_AVG) result_q <= acc_n;
        end
        ST_DIV: begin
          sum_q <= sum_n;
          rem_q <= rem_n;
          div_q <= div_q + 1'b1;
          if (div_last) result_q <= sum_n[DW-1:0];
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_stat_sequencer.sv
// tb_stat_sequencer: scoreboard bench for stat_sequencer with a one-cycle-latency memory model
module tb_stat_sequencer;
  localparam int DW = 8;
  localparam int AW = 8;
  logic          CLK = 1'b0, RESET = 1'b0, start = 1'b0;
  logic [1:0]    opcode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    length = '0;
  logic          mem_rd, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] result;
  logic [DW-1:0] mem [256];
  typedef struct {
    logic [DW-1:0] res;
    logic          e;
    int            lat;
    int            nrd;
  } exp_t;
  exp_t          sb[$];
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] obs_addr[$];
  int tests = 0;
  int fails = 0;

  stat_sequencer #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .opcode(opcode), .base_addr(base_addr),
    .length(length), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (mem_rd) begin
      mem_data <= mem[mem_addr];
      obs_addr.push_back(mem_addr);
    end

  task automatic run_op(input logic [1:0] op, input logic [7:0] base, input logic [7:0] n,
                        input bit poke);
    exp_t x, g;
    logic [DW-1:0] a;
    logic [AW-1:0] p;
    int s, j;
    bit ok;
    exp_addr.delete();
    obs_addr.delete();
    if (n == 0 || op == 2'b11) begin
      x.res = '0; x.e = 1'b1; x.lat = 2; x.nrd = 0;
    end else begin
      a = (op == 2'b01) ? '1 : '0;
      s = 0;
      for (int i = 0; i < int'(n); i++) begin
        p = base + AW'(i);
        exp_addr.push_back(p);
        s += int'(mem[p]);
        if (op == 2'b00 && mem[p] > a) a = mem[p];
        if (op == 2'b01 && mem[p] < a) a = mem[p];
      end
      x.res = (op == 2'b10) ? DW'(s / int'(n)) : a;
      x.e   = 1'b0;
      x.nrd = int'(n);
      x.lat = 2 * int'(n) + 2 + ((op == 2'b10) ? DW + 8 : 0);
    end
    sb.push_back(x);
    start = 1'b1; opcode = op; base_addr = base; length = n;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    j = 1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start op=%0d got %b want 1", op, busy);
    end
    while (done !== 1'b1 && j < 1000) begin
      @(negedge CLK);
      j++;
      if (poke && j == 2) begin
        start = 1'b1; opcode = 2'b01; base_addr = base + 8'd100; length = 8'd1;
      end else start = 1'b0;
    end
    start = 1'b0;
    g = sb.pop_front();
    tests++;
    if (j != g.lat) begin
      fails++;
      $display("FAIL latency op=%0d n=%0d got %0d want %0d", op, n, j, g.lat);
    end
    tests++;
    if (result !== g.res) begin
      fails++;
      $display("FAIL result op=%0d n=%0d got %0d want %0d", op, n, result, g.res);
    end
    tests++;
    if (err !== g.e) begin
      fails++;
      $display("FAIL err op=%0d n=%0d got %b want %b", op, n, err, g.e);
    end
    tests++;
    if (obs_addr.size() != g.nrd) begin
      fails++;
      $display("FAIL rd_count op=%0d got %0d want %0d", op, obs_addr.size(), g.nrd);
    end
    ok = obs_addr.size() == exp_addr.size();
    for (int i = 0; ok && i < exp_addr.size(); i++) if (obs_addr[i] !== exp_addr[i]) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rd_addrs op=%0d base=%0d got %p want %p", op, base, obs_addr, exp_addr);
    end
    @(negedge CLK);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    tests++;
    if ({busy, done, err, mem_rd} !== 4'b0 || result !== '0 || mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_state got busy=%b done=%b err=%b rd=%b res=%0d addr=%0d want all 0",
               busy, done, err, mem_rd, result, mem_addr);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_max();
    mem[10] = 8'd3; mem[11] = 8'd9; mem[12] = 8'd2; mem[13] = 8'd7;
    run_op(2'b00, 8'd10, 8'd4, 1'b0);
  endtask

  task automatic test_avg();
    mem[20] = 8'd255; mem[21] = 8'd255; mem[22] = 8'd1;
    run_op(2'b10, 8'd20, 8'd3, 1'b0);
  endtask

  task automatic test_min_wrap();
    mem[254] = 8'd50; mem[255] = 8'd200; mem[0] = 8'd17;
    run_op(2'b01, 8'd254, 8'd3, 1'b0);
  endtask

  task automatic test_errors();
    run_op(2'b00, 8'd10, 8'd0, 1'b0);
    run_op(2'b11, 8'd10, 8'd5, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_op(2'b00, 8'd10, 8'd4, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem[30] = 8'd100; mem[31] = 8'd200; mem[32] = 8'd50;
    start = 1'b1; opcode = 2'b10; base_addr = 8'd30; length = 8'd3;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, mem_rd} !== 4'b0 || result !== '0 || mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_mid got busy=%b done=%b err=%b rd=%b res=%0d addr=%0d want all 0",
               busy, done, err, mem_rd, result, mem_addr);
    end
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done) seen = 1;
    end
    RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (done) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_no_done got done seen want none");
    end
    run_op(2'b10, 8'd30, 8'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 255));
      run_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)), 1'b0);
    end
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 255));
    run_op(2'b10, 8'd77, 8'd255, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_max();
    test_avg();
    test_min_wrap();
    test_errors();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
